uart_cfg_seq: RTL and testbench
===============================

UART_CFG_SEQ -- requirements
Module: uart_cfg_seq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000, UART register base (RBR/THR at +0x00 … SCR at +0x1C).
REQ-002 SHALL have parameter DIVISOR, default 16'd54, baud divisor loaded into DLL/DLM.
REQ-003 SHALL have parameter LCR_CFG, default 8'h03, final LCR value (8N1, DLAB=0).
REQ-004 SHALL have parameter FCR_CFG, default 8'hC7, FCR value (FIFO enable, both FIFO resets, trigger 14).
REQ-005 SHALL have parameter IER_CFG, default 8'h00, IER value.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port start  input  1  one-cycle pulse requesting the init sequence.
REQ-009 SHALL have port busy  output  1  high while the init sequence runs.
REQ-010 SHALL have port init_done  output  1  high once init has completed, until the next start or reset.
REQ-011 SHALL have ports tx_valid input 1, tx_ready output 1, tx_data input 8  byte stream to transmit.
REQ-012 SHALL have ports m_req output 1, m_we output 1, m_addr output 32, m_wdata output 32  register bus master request.
REQ-013 SHALL have ports m_ack input 1, m_rdata input 32  register bus completion and read data.
REQ-014 SHALL have port err  output 1  sticky bus-timeout flag.

Function
REQ-015 SHALL implement states IDLE, W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR, W_IER, READY, RD_LSR, W_THR, ERR.
REQ-016 SHALL in IDLE, on start, move to W_LCR_DLAB and assert busy on the next cycle.
REQ-017 SHALL issue writes in order: LCR=LCR_CFG|0x80, DLL=DIVISOR[7:0], DLM=DIVISOR[15:8], LCR=LCR_CFG&0x7F, FCR=FCR_CFG, IER=IER_CFG, each zero-extended to 32 bits at BASE_ADDR+offset.
REQ-018 SHALL hold m_req, m_we, m_addr, m_wdata stable from the request's assertion until m_ack is sampled high; m_req deasserts the cycle after ack and stays low for exactly one cycle before the next request.
REQ-019 SHALL treat m_ack outside an outstanding request as ignored.
REQ-020 SHALL, after the IER write acks, enter READY, deassert busy, assert init_done in the same cycle.
REQ-021 SHALL in READY with tx_valid high, issue a read of LSR (m_we=0); if m_rdata[5] (THRE) is 1 at ack, go to W_THR, else re-read LSR after the one-cycle gap.
REQ-022 SHALL in W_THR write {24'h0,tx_data} to THR, assert tx_ready for exactly the one cycle that m_ack is sampled, then return to READY.
REQ-023 SHALL capture tx_data when the THR request is launched; tx_data/tx_valid SHALL be held stable by the source until tx_ready.
REQ-024 SHALL tx_ready remain 0 outside READY/W_THR flow and before init_done.
REQ-025 SHALL ignore start while busy; start in READY (no outstanding transaction) restarts init, clears init_done.
REQ-026 SHALL ignore start in RD_LSR/W_THR until the transaction acks, then restart init instead of continuing TX.

Reset
REQ-027 SHALL on rst_n low asynchronously force state IDLE and outputs busy=0, init_done=0, tx_ready=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, err=0.
REQ-028 SHALL abandon any outstanding bus transaction on reset, no completion awaited.

Configuration
REQ-029 SHALL, with UART_CFG_SEQ_TIMEOUT_EN defined, count cycles of an outstanding request; at 256 cycles without m_ack, drop m_req, set err, enter ERR; leave ERR only via start (clears err, restarts init).
REQ-030 SHALL, without UART_CFG_SEQ_TIMEOUT_EN, wait for m_ack indefinitely; err tied 0; ERR state unreachable.

Verification
REQ-031 start with ack after 1 cycle each -> six writes: 0x100C=0x83, 0x1000=0x36, 0x1004=0x00, 0x100C=0x03, 0x1008=0xC7, 0x1004=0x00; then init_done=1, busy=0.
REQ-032 tx_valid=1, tx_data=0x5A, LSR reads 0x00,0x00,0x60 -> three LSR reads, then THR write 0x1000=0x5A, tx_ready single-cycle pulse.
REQ-033 m_ack delayed 10 cycles on DLL write -> m_addr/m_wdata stable for all 10 cycles, sequence continues unchanged.
REQ-034 rst_n low mid DLM write -> all outputs zero same cycle; after release, start reruns full sequence from LCR.
REQ-035 with UART_CFG_SEQ_TIMEOUT_EN, never ack FCR write -> after 256 cycles m_req=0, err=1; start clears err and restarts at LCR write.
REQ-036 start pulse while busy -> ignored, write order and count unchanged.

Source files
------------

// File: rtl/uart_cfg_seq.sv
// UART 16550 init sequencer and TX byte pump driving a simple register bus.
// Optional bus-timeout watchdog enabled by defining UART_CFG_SEQ_TIMEOUT_EN.
module uart_cfg_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h1000,
    parameter logic [15:0] DIVISOR   = 16'd54,
    parameter logic [7:0]  LCR_CFG   = 8'h03,
    parameter logic [7:0]  FCR_CFG   = 8'hC7,
    parameter logic [7:0]  IER_CFG   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err
);

    localparam logic [7:0] OFF_THR = 8'h00;
    localparam logic [7:0] OFF_DLL = 8'h00;
    localparam logic [7:0] OFF_DLM = 8'h04;
    localparam logic [7:0] OFF_IER = 8'h04;
    localparam logic [7:0] OFF_FCR = 8'h08;
    localparam logic [7:0] OFF_LCR = 8'h0C;
    localparam logic [7:0] OFF_LSR = 8'h14;

    typedef enum logic [3:0] {
        IDLE, W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR,
        W_IER, READY, RD_LSR, W_THR, ERR
    } state_t;

    state_t      state_q, state_d, nxt_wr;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pend_q, pend_d;
    logic        tgt_we;
    logic [7:0]  tgt_off;
    logic [7:0]  tgt_data;
    logic        xfer, launch, acked, timeout;
    logic        unused_rdata;

    assign unused_rdata = ^{m_rdata[31:6], m_rdata[4:0]};

    assign xfer = state_q inside {W_LCR_DLAB, W_DLL, W_DLM, W_LCR,
                                  W_FCR, W_IER, RD_LSR, W_THR};
    // A request launches on the first cycle in a bus state with m_req low,
    // which yields exactly one idle cycle after each ack.
    assign launch = xfer & ~req_q;
    assign acked  = req_q & m_ack;

`ifdef UART_CFG_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign timeout = req_q & ~m_ack & (cnt_q == 8'hFF);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (launch) begin
            cnt_d = 8'h00;
        end else if (req_q) begin
            cnt_d = cnt_q + 8'h01;
        end
        if (timeout) begin
            err_d = 1'b1;
        end else if (state_q == ERR && start) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        tgt_we   = 1'b1;
        tgt_off  = OFF_THR;
        tgt_data = 8'h00;
        nxt_wr   = IDLE;
        unique case (state_q)
            W_LCR_DLAB: begin
                tgt_off  = OFF_LCR;
                tgt_data = LCR_CFG | 8'h80;
                nxt_wr   = W_DLL;
            end
            W_DLL: begin
                tgt_off  = OFF_DLL;
                tgt_data = DIVISOR[7:0];
                nxt_wr   = W_DLM;
            end
            W_DLM: begin
                tgt_off  = OFF_DLM;
                tgt_data = DIVISOR[15:8];
                nxt_wr   = W_LCR;
            end
            W_LCR: begin
                tgt_off  = OFF_LCR;
                tgt_data = LCR_CFG & 8'h7F;
                nxt_wr   = W_FCR;
            end
            W_FCR: begin
                tgt_off  = OFF_FCR;
                tgt_data = FCR_CFG;
                nxt_wr   = W_IER;
            end
            W_IER: begin
                tgt_off  = OFF_IER;
                tgt_data = IER_CFG;
                nxt_wr   = READY;
            end
            RD_LSR: begin
                tgt_we  = 1'b0;
                tgt_off = OFF_LSR;
            end
            W_THR: begin
                tgt_off  = OFF_THR;
                tgt_data = tx_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;

        if (launch) begin
            req_d   = 1'b1;
            we_d    = tgt_we;
            addr_d  = BASE_ADDR + {24'h0, tgt_off};
            wdata_d = {24'h0, tgt_data};
        end
        if (acked) begin
            req_d = 1'b0;
        end

        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d = W_LCR_DLAB;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR: begin
                if (acked) begin
                    state_d = nxt_wr;
                end
            end
            W_IER: begin
                if (acked) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            READY: begin
                if (start) begin
                    state_d = W_LCR_DLAB;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (tx_valid) begin
                    state_d = RD_LSR;
                end
            end
            RD_LSR, W_THR: begin
                // A start seen mid-transfer is held until the bus ack.
                pend_d = pend_q | start;
                if (acked) begin
                    if (pend_q | start) begin
                        state_d = W_LCR_DLAB;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pend_d  = 1'b0;
                    end else if (state_q == W_THR) begin
                        state_d = READY;
                    end else if (m_rdata[5]) begin
                        state_d = W_THR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            req_d   = 1'b0;
            state_d = ERR;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign busy      = busy_q;
    assign init_done = done_q;
    assign m_req     = req_q;
    assign m_we      = we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign tx_ready  = (state_q == W_THR) & acked;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// Self-checking bench for uart_cfg_seq: bus responder, transaction logger
// and expected-transaction tables compared in a loop.
module tb_uart_cfg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        busy, init_done, tx_ready;
    logic        m_req, m_we, err;
    logic [31:0] m_addr, m_wdata;

    always #5 clk = ~clk;

    uart_cfg_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .init_done (init_done),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .err       (err)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        int          gap;
    } log_t;

    int   errors = 0;
    int   checks = 0;
    exp_t ex[$];
    log_t lg[$];
    logic [7:0] lsr_q[$];

    int ridx = 0;
    int wcnt = 0;
    int slow_idx = -1;
    int slow_dly = 1;
    int noack_idx = -1;
    bit stray = 1'b0;

    int   low_cnt = 0;
    int   txr_cnt = 0;
    int   txr_bad = 0;
    int   stab_bad = 0;
    logic prev_req = 1'b0;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    int          cur_hold, cur_gap;

    // Bus responder: acks after a per-transaction delay, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (m_req === 1'b1) begin
            wcnt++;
            if (ridx != noack_idx &&
                wcnt >= ((ridx == slow_idx) ? slow_dly : 1)) begin
                m_ack = 1'b1;
                if (!m_we && lsr_q.size() > 0) begin
                    m_rdata = {24'h0, lsr_q.pop_front()};
                end else begin
                    m_rdata = 32'h60;
                end
                ridx++;
            end else begin
                m_ack = 1'b0;
            end
        end else begin
            wcnt    = 0;
            m_ack   = stray;
            m_rdata = 32'h0;
        end
    end

    // Transaction logger: one entry per request, pushed when m_req falls.
    initial forever begin
        @(negedge clk);
        #1;
        if (m_req === 1'b1) begin
            if (!prev_req) begin
                cur_we    = m_we;
                cur_addr  = m_addr;
                cur_wdata = m_wdata;
                cur_hold  = 1;
                cur_gap   = low_cnt;
                low_cnt   = 0;
            end else begin
                if ({m_we, m_addr, m_wdata} !== {cur_we, cur_addr, cur_wdata})
                    stab_bad++;
                cur_hold++;
            end
        end else begin
            if (prev_req)
                lg.push_back('{cur_we, cur_addr, cur_wdata, cur_hold, cur_gap});
            low_cnt++;
        end
        if (tx_ready === 1'b1) begin
            txr_cnt++;
            if (!(m_req && m_ack && m_we && m_addr == 32'h1000))
                txr_bad++;
        end
        prev_req = m_req;
    end

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear();
        lg.delete();
        ex.delete();
        lsr_q.delete();
        ridx      = 0;
        txr_cnt   = 0;
        txr_bad   = 0;
        stab_bad  = 0;
        slow_idx  = -1;
        noack_idx = -1;
    endtask

    task automatic add(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input int h);
        ex.push_back('{we, a, d, h});
    endtask

    task automatic add_init(input int dll_hold);
        add(1'b1, 32'h100C, 32'h83, 1);
        add(1'b1, 32'h1000, 32'h36, dll_hold);
        add(1'b1, 32'h1004, 32'h00, 1);
        add(1'b1, 32'h100C, 32'h03, 1);
        add(1'b1, 32'h1008, 32'hC7, 1);
        add(1'b1, 32'h1004, 32'h00, 1);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, " count"}, 96'(lg.size()), 96'(ex.size()));
        for (int i = 0; i < ex.size(); i++) begin
            if (i < lg.size()) begin
                chk($sformatf("%s txn%0d", tag, i),
                    {31'h0, lg[i].we, lg[i].addr,
                     ex[i].we ? lg[i].wdata : 32'h0},
                    {31'h0, ex[i].we, ex[i].addr,
                     ex[i].we ? ex[i].wdata : 32'h0});
                chk($sformatf("%s hold%0d", tag, i),
                    96'(lg[i].hold), 96'(ex[i].hold));
                if (i > 0)
                    chk($sformatf("%s gap%0d", tag, i), 96'(lg[i].gap), 96'd1);
            end
        end
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!(init_done === 1'b1 && busy === 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, " init_done"}, 96'({busy, init_done}), 96'b01);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        chk("reset outputs",
            96'({busy, init_done, tx_ready, m_req, m_we, m_addr, m_wdata, err}),
            96'h0);
        rst_n = 1'b1;
        tick();

        // Basic init; tx_valid high during init must not leak through
        clear();
        add_init(1);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        chk("idle no req", 96'({m_req, busy}), 96'h0);
        start = 1'b1;
        tick();
        chk("busy after start", 96'(busy), 96'd1);
        start = 1'b0;
        wait_init("init");
        tx_valid = 1'b0;
        tick();
        tick();
        cmp_log("init");
        chk("init no tx_ready", 96'(txr_cnt), 96'd0);

        // TX with two not-ready LSR reads
        clear();
        lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h60);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        n = 0;
        while (txr_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        tx_valid = 1'b0;
        repeat (5) tick();
        add(1'b0, 32'h1014, 32'h0, 1);
        add(1'b0, 32'h1014, 32'h0, 1);
        add(1'b0, 32'h1014, 32'h0, 1);
        add(1'b1, 32'h1000, 32'h5A, 1);
        cmp_log("tx");
        chk("tx_ready pulses", 96'(txr_cnt), 96'd1);
        chk("tx_ready on ack", 96'(txr_bad), 96'd0);
        chk("tx busy/done", 96'({busy, init_done}), 96'b01);

        // Restart from READY, slow DLL ack
        clear();
        slow_idx = 1;
        slow_dly = 10;
        add_init(10);
        pulse_start();
        chk("restart clears done", 96'({busy, init_done}), 96'b10);
        wait_init("slow");
        tick();
        tick();
        cmp_log("slow");
        chk("slow stable", 96'(stab_bad), 96'd0);

        // Start while busy, stray acks between requests
        clear();
        add_init(1);
        stray = 1'b1;
        pulse_start();
        n = 0;
        while (lg.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        pulse_start();
        wait_init("dbl");
        repeat (10) tick();
        stray = 1'b0;
        cmp_log("dbl");
        chk("dbl idle", 96'({busy, init_done, m_req}), 96'b010);

        // Start during an outstanding LSR read restarts init after ack
        clear();
        lsr_q.push_back(8'h00);
        slow_idx = 0;
        slow_dly = 5;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        n = 0;
        while (m_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        pulse_start();
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tx_valid = 1'b0;
        wait_init("rdrst");
        tick();
        tick();
        add(1'b0, 32'h1014, 32'h0, 5);
        add_init(1);
        cmp_log("rdrst");
        chk("rdrst tx_ready", 96'(txr_cnt), 96'd0);

        // Reset in the middle of the DLM write
        clear();
        slow_idx = 2;
        slow_dly = 20;
        pulse_start();
        n = 0;
        while (!(m_req === 1'b1 && m_addr == 32'h1004) && n < 100) begin
            tick();
            n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs",
            96'({busy, init_done, tx_ready, m_req, m_we, m_addr, m_wdata, err}),
            96'h0);
        tick();
        tick();
        clear();
        add_init(1);
        rst_n = 1'b1;
        tick();
        pulse_start();
        wait_init("post-rst");
        tick();
        tick();
        cmp_log("post-rst");

`ifdef UART_CFG_SEQ_TIMEOUT_EN
        // FCR write never acked
        clear();
        noack_idx = 4;
        pulse_start();
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        tick();
        chk("timeout flags", 96'({m_req, err, busy}), 96'b010);
        add(1'b1, 32'h100C, 32'h83, 1);
        add(1'b1, 32'h1000, 32'h36, 1);
        add(1'b1, 32'h1004, 32'h00, 1);
        add(1'b1, 32'h100C, 32'h03, 1);
        add(1'b1, 32'h1008, 32'hC7, 256);
        cmp_log("tmo");
        clear();
        add_init(1);
        pulse_start();
        chk("err cleared", 96'({err, busy}), 96'b01);
        wait_init("tmo-rerun");
        tick();
        tick();
        cmp_log("tmo-rerun");
`else
        chk("err tied low", 96'(err), 96'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
